instr_sequencer: RTL and testbench

- Front-end controller for the mipscpu instruction interface (Instrword / Newinstr).
- A host loads a queue of 32-bit MIPS instruction words, then pulses Start.
- The block issues each word to the CPU: Instrword is presented first, then a one-cycle Newinstr pulse follows, then a fixed execution gap is allowed before the next word.
- It replaces hand-timed testbench sequencing and supports a halt marker and abort.

---
 rtl/instr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// instr_sequencer : queues MIPS instruction words from a host and issues them
//                   to the CPU as Instrword + one-cycle Newinstr strobes.
// Revision 1.0
// ============================================================================
module instr_sequencer #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter int          ISSUE_GAP = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Load_valid,
  input  logic [31:0]   Load_word,
  output logic          Load_ready,
  input  logic          Start,
  input  logic          Abort,
  output logic [31:0]   Instrword,
  output logic          Newinstr,
  output logic          Busy,
  output logic          Done,
  output logic [AW:0]   Count,
  output logic [7:0]    Issued
);

  localparam int              GW     = $clog2(ISSUE_GAP + 1);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0]   C_GAP  = GW'(ISSUE_GAP);
  localparam logic [GW-1:0]   C_ONE  = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic            newinstr_q, newinstr_d;
  logic [7:0]      issued_q, issued_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     mem_q [DEPTH];

  logic            push_en;
  logic            pop;
  logic [31:0]     head;

  assign head       = mem_q[rd_ptr_q];
  assign Load_ready = (count_q != C_FULL);
  // An aborting cycle drops any concurrent push so the flush leaves the queue empty.
  assign push_en    = Load_valid && Load_ready && !Abort;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    newinstr_d = newinstr_q;
    issued_d   = issued_q;
    gap_d      = gap_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (count_q != '0) begin
            state_d  = S_SETUP;
            issued_d = '0;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_SETUP: begin
        pop = 1'b1;
        if (head == HALT_WORD) begin
          state_d = S_DONE;
        end else begin
          instr_d = head;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        newinstr_d = 1'b1;
        issued_d   = issued_q + 8'd1;
        gap_d      = C_GAP;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        newinstr_d = 1'b0;
        if (gap_q <= C_ONE) begin
          gap_d   = '0;
          state_d = (count_q != '0) ? S_SETUP : S_DONE;
        end else begin
          gap_d   = gap_q - C_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (Abort) begin
      state_d    = S_IDLE;
      newinstr_d = 1'b0;
      gap_d      = '0;
      pop        = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_en && pop) begin
      count_d = count_q - 1'b1;
    end
    // Flush by catching the read pointer up to the write pointer.
    if (Abort) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      newinstr_q <= 1'b0;
      issued_q   <= '0;
      gap_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      newinstr_q <= newinstr_d;
      issued_q   <= issued_d;
      gap_q      <= gap_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= Load_word;
    end
  end

  assign Instrword = instr_q;
  assign Newinstr  = newinstr_q;
  assign Issued    = issued_q;
  assign Count     = count_q;
  assign Busy      = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_WAIT);
  assign Done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_instr_sequencer : directed self-checking bench for instr_sequencer
// Revision 1.0
// ============================================================================
module tb_instr_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Load_valid;
  logic [31:0] Load_word;
  logic        Load_ready;
  logic        Start;
  logic        Abort;
  logic [31:0] Instrword;
  logic        Newinstr;
  logic        Busy;
  logic        Done;
  logic [3:0]  Count;
  logic [7:0]  Issued;

  instr_sequencer #(
    .DEPTH     (8),
    .AW        (3),
    .ISSUE_GAP (4),
    .HALT_WORD (32'hFFFF_FFFF)
  ) u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load_valid (Load_valid),
    .Load_word  (Load_word),
    .Load_ready (Load_ready),
    .Start      (Start),
    .Abort      (Abort),
    .Instrword  (Instrword),
    .Newinstr   (Newinstr),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count),
    .Issued     (Issued)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          n_vec;
  int          n_err;
  int          np;
  int          nd;
  int          done_k;
  logic        busy0;
  int          pulse_k   [16];
  logic [31:0] pulse_w   [16];
  logic [31:0] pulse_pre [16];
  logic [31:0] words     [9];
  logic        rdy_seen  [9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    Load_valid = 1'b1;
    Load_word  = w;
    tick();
    Load_valid = 1'b0;
  endtask

  // Raise Start, then log pulses and Done; k=0 is the edge that samples Start.
  task automatic start_and_run(input int budget);
    logic [31:0] prev_w;
    np     = 0;
    nd     = 0;
    done_k = -1;
    busy0  = 1'b0;
    prev_w = Instrword;
    Start  = 1'b1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (k == 0) begin
        Start = 1'b0;
        busy0 = Busy;
      end
      if (Newinstr) begin
        if (np < 16) begin
          pulse_k[np]   = k;
          pulse_w[np]   = Instrword;
          pulse_pre[np] = prev_w;
        end
        np++;
      end
      if (Done) begin
        nd++;
        if (done_k < 0) done_k = k;
      end
      prev_w = Instrword;
      if (done_k >= 0 && k > done_k + 1) break;
    end
    check("done_within_budget", 32'(done_k >= 0), 32'd1);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    Reset      = 1'b0;
    Load_valid = 1'b0;
    Load_word  = '0;
    Start      = 1'b0;
    Abort      = 1'b0;
    repeat (2) tick();

    check("rst_instrword", Instrword, 32'h0);
    check("rst_newinstr", 32'(Newinstr), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_issued", 32'(Issued), 32'd0);
    check("rst_ready", 32'(Load_ready), 32'd1);
    Reset = 1'b1;
    tick();

    // Empty queue start: Done only, no issue.
    start_and_run(10);
    check("empty_done_k", 32'(done_k), 32'd0);
    check("empty_done_n", 32'(nd), 32'd1);
    check("empty_pulses", 32'(np), 32'd0);
    check("empty_issued", 32'(Issued), 32'd0);

    // Three-word run.
    push(32'h8C01_0000);
    push(32'h8C02_0001);
    push(32'h8C03_0002);
    check("t1_count_loaded", 32'(Count), 32'd3);
    start_and_run(60);
    check("t1_busy_start", 32'(busy0), 32'd1);
    check("t1_pulses", 32'(np), 32'd3);
    check("t1_p0_k", 32'(pulse_k[0]), 32'd2);
    check("t1_p1_k", 32'(pulse_k[1]), 32'd8);
    check("t1_p2_k", 32'(pulse_k[2]), 32'd14);
    check("t1_w0", pulse_w[0], 32'h8C01_0000);
    check("t1_w1", pulse_w[1], 32'h8C02_0001);
    check("t1_w2", pulse_w[2], 32'h8C03_0002);
    check("t1_w0_pre", pulse_pre[0], 32'h8C01_0000);
    check("t1_w2_pre", pulse_pre[2], 32'h8C03_0002);
    check("t1_done_k", 32'(done_k), 32'd18);
    check("t1_done_n", 32'(nd), 32'd1);
    check("t1_issued", 32'(Issued), 32'd3);
    check("t1_count", 32'(Count), 32'd0);
    check("t1_busy_end", 32'(Busy), 32'd0);

    // Halt marker stops the run and is consumed, the word behind it stays.
    push(32'h0022_2020);
    push(32'hFFFF_FFFF);
    push(32'h0083_2822);
    start_and_run(40);
    check("t2_pulses", 32'(np), 32'd1);
    check("t2_w0", pulse_w[0], 32'h0022_2020);
    check("t2_done_k", 32'(done_k), 32'd7);
    check("t2_done_n", 32'(nd), 32'd1);
    check("t2_count", 32'(Count), 32'd1);
    check("t2_issued", 32'(Issued), 32'd1);
    check("t2_instr_held", Instrword, 32'h0022_2020);
    start_and_run(40);
    check("t2b_pulses", 32'(np), 32'd1);
    check("t2b_w0", pulse_w[0], 32'h0083_2822);
    check("t2b_done_k", 32'(done_k), 32'd6);
    check("t2b_issued", 32'(Issued), 32'd1);

    // Overfill: nine offered, eight kept, pointers wrap.
    Load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      words[i]    = 32'h2008_0000 | 32'(i);
      Load_word   = words[i];
      rdy_seen[i] = Load_ready;
      tick();
    end
    Load_valid = 1'b0;
    check("t3_ready_8th", 32'(rdy_seen[7]), 32'd1);
    check("t3_ready_9th", 32'(rdy_seen[8]), 32'd0);
    check("t3_count_full", 32'(Count), 32'd8);
    check("t3_ready_full", 32'(Load_ready), 32'd0);
    start_and_run(100);
    check("t3_pulses", 32'(np), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_w%0d", i), pulse_w[i], words[i]);
    end
    check("t3_p7_k", 32'(pulse_k[7]), 32'd44);
    check("t3_done_k", 32'(done_k), 32'd48);
    check("t3_issued", 32'(Issued), 32'd8);
    check("t3_count", 32'(Count), 32'd0);

    // Abort in WAIT after second issue of a five-word run.
    for (int i = 0; i < 5; i++) push(32'h1000_0000 + 32'(i));
    Start = 1'b1;
    nd    = 0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      Start = 1'b0;
      if (Done) nd++;
    end
    check("t4_busy_wait", 32'(Busy), 32'd1);
    Abort      = 1'b1;
    Load_valid = 1'b1;
    Load_word  = 32'hDEAD_BEEF;
    tick();
    Abort      = 1'b0;
    Load_valid = 1'b0;
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_count", 32'(Count), 32'd0);
    check("t4_newinstr", 32'(Newinstr), 32'd0);
    check("t4_instr", Instrword, 32'h1000_0001);
    check("t4_issued", 32'(Issued), 32'd2);
    tick();
    if (Done) nd++;
    check("t4_no_done", 32'(nd), 32'd0);
    check("t4_count_after", 32'(Count), 32'd0);

    // Asynchronous reset while in PULSE.
    push(32'hABCD_0001);
    push(32'hABCD_0002);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("t5_instr_pre", Instrword, 32'hABCD_0001);
    #2;
    Reset = 1'b0;
    #1;
    check("t5_instrword", Instrword, 32'h0);
    check("t5_newinstr", 32'(Newinstr), 32'd0);
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_done", 32'(Done), 32'd0);
    check("t5_count", 32'(Count), 32'd0);
    check("t5_issued", 32'(Issued), 32'd0);
    check("t5_ready", 32'(Load_ready), 32'd1);
    tick();
    Reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
